// File: rtl/fp_normalizer_if.sv
// Request/result bundle between a producer of unnormalized floats and fp_normalizer.
// The master drives the operands and start; the slave returns status and the normalized result.
interface fp_normalizer_if;
   logic        start;
   logic        sign_in;
   logic [7:0]  exponent_in;
   logic [24:0] significand_in;
   logic        busy;
   logic        done;
   logic        sign_out;
   logic [7:0]  exponent_out;
   logic [22:0] mantissa_out;
   logic        zero;
   logic        overflow;
   logic        underflow;

   modport master (
      output start, sign_in, exponent_in, significand_in,
      input  busy, done, sign_out, exponent_out, mantissa_out, zero, overflow, underflow
   );

   modport slave (
      input  start, sign_in, exponent_in, significand_in,
      output busy, done, sign_out, exponent_out, mantissa_out, zero, overflow, underflow
   );
endinterface

// File: rtl/fp_normalizer.sv
// Multi-cycle normalizer for single-precision results.
// Handles a one-bit carry right shift and a one-bit-per-cycle left shift, with exponent saturation and denormal detection.
module fp_normalizer (
   input logic            clk,
   input logic            reset,
   fp_normalizer_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      CHECK       = 3'd1,
      SHIFT_RIGHT = 3'd2,
      SHIFT_LEFT  = 3'd3,
      DONE        = 3'd4
   } stateT;

   stateT       stateR, stateNextS;
   logic [24:0] sigR, sigNextS, sigShlS;
   logic [8:0]  expR, expNextS, expIncS, expDecS;
   logic        sgnR, sgnNextS;
   logic        zeroR, zeroNextS;
   logic        ovfR, ovfNextS;
   logic        udfR, udfNextS;
   logic        busyR, doneR, signOutR;
   logic [7:0]  expOutR;
   logic [22:0] mantOutR;

   // Next-state and datapath decisions for the normalization sequence
   always_comb begin
      stateNextS = stateR;
      sigNextS   = sigR;
      expNextS   = expR;
      sgnNextS   = sgnR;
      zeroNextS  = zeroR;
      ovfNextS   = ovfR;
      udfNextS   = udfR;
      sigShlS    = {sigR[23:0], 1'b0};
      expIncS    = expR + 9'd1;
      expDecS    = expR - 9'd1;

      case (stateR)
         IDLE: begin
            if (bus.start) begin
               sigNextS   = bus.significand_in;
               expNextS   = {1'b0, bus.exponent_in};
               sgnNextS   = bus.sign_in;
               zeroNextS  = 1'b0;
               ovfNextS   = 1'b0;
               udfNextS   = 1'b0;
               stateNextS = CHECK;
            end else begin
               stateNextS = IDLE;
            end
         end
         CHECK: begin
            if (sigR == 25'd0) begin
               zeroNextS  = 1'b1;
               expNextS   = 9'd0;
               stateNextS = DONE;
            end else if (sigR[24]) begin
               stateNextS = SHIFT_RIGHT;
            end else if (sigR[23]) begin
               stateNextS = DONE;
            end else if (expR <= 9'd1) begin
               udfNextS   = 1'b1;
               expNextS   = 9'd0;
               stateNextS = DONE;
            end else begin
               stateNextS = SHIFT_LEFT;
            end
         end
         SHIFT_RIGHT: begin
            // The dropped LSB is folded into the new LSB so the rounder still sees it as sticky.
            sigNextS   = {1'b0, sigR[24:2], sigR[1] | sigR[0]};
            stateNextS = DONE;
            if (expIncS >= 9'd255) begin
               expNextS       = 9'd255;
               sigNextS[22:0] = 23'd0;
               ovfNextS       = 1'b1;
            end else begin
               expNextS = expIncS;
            end
         end
         SHIFT_LEFT: begin
            sigNextS = sigShlS;
            expNextS = expDecS;
            if (sigShlS[23]) begin
               stateNextS = DONE;
            end else if (expDecS == 9'd1) begin
               udfNextS   = 1'b1;
               expNextS   = 9'd0;
               stateNextS = DONE;
            end else begin
               stateNextS = SHIFT_LEFT;
            end
         end
         DONE: begin
            stateNextS = IDLE;
         end
         default: begin
            stateNextS = IDLE;
         end
      endcase
   end

   // State, working registers and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         stateR   <= IDLE;
         sigR     <= 25'd0;
         expR     <= 9'd0;
         sgnR     <= 1'b0;
         zeroR    <= 1'b0;
         ovfR     <= 1'b0;
         udfR     <= 1'b0;
         busyR    <= 1'b0;
         doneR    <= 1'b0;
         signOutR <= 1'b0;
         expOutR  <= 8'd0;
         mantOutR <= 23'd0;
      end else begin
         stateR <= stateNextS;
         sigR   <= sigNextS;
         expR   <= expNextS;
         sgnR   <= sgnNextS;
         zeroR  <= zeroNextS;
         ovfR   <= ovfNextS;
         udfR   <= udfNextS;
         busyR  <= (stateNextS != IDLE);
         doneR  <= (stateNextS == DONE);
         // Result registers load only on entry to DONE and hold until the next result.
         if (stateNextS == DONE) begin
            signOutR <= sgnNextS;
            expOutR  <= expNextS[7:0];
            mantOutR <= sigNextS[22:0];
         end
      end
   end

   assign bus.busy         = busyR;
   assign bus.done         = doneR;
   assign bus.sign_out     = signOutR;
   assign bus.exponent_out = expOutR;
   assign bus.mantissa_out = mantOutR;
   assign bus.zero         = zeroR;
   assign bus.overflow     = ovfR;
   assign bus.underflow    = udfR;

endmodule

// File: tb/tb_fp_normalizer.sv
// Table-driven bench for fp_normalizer with an expected-result queue and a few control sequences.
module tb_fp_normalizer;

   logic clk;
   logic reset;
   int   nChecks;
   int   nFails;

   fp_normalizer_if bus ();

   fp_normalizer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        sgn;
      logic [7:0]  ein;
      logic [24:0] sin;
      logic [7:0]  eout;
      logic [22:0] mout;
      logic        z;
      logic        o;
      logic        u;
      int          lat;   // edges after the start edge until done is seen
   } vecT;

   vecT vecs[12];
   vecT sbQ[$];
   vecT tmpV;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      nChecks++;
      if (act !== req) begin
         nFails++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic driveStart(input vecT v, input bit push);
      @(negedge clk);
      bus.start          = 1'b1;
      bus.sign_in        = v.sgn;
      bus.exponent_in    = v.ein;
      bus.significand_in = v.sin;
      if (push) sbQ.push_back(v);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic waitDone(input int elapsed);
      vecT e;
      int  lat;
      bit  seen;
      lat  = elapsed;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.done === 1'b1) seen = 1'b1;
      end
      if (sbQ.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = sbQ.pop_front();
         check("done_seen", {31'd0, seen}, 32'd1);
         if (seen) begin
            check("latency", lat, e.lat);
            check("sign_out", {31'd0, bus.sign_out}, {31'd0, e.sgn});
            check("exponent_out", {24'd0, bus.exponent_out}, {24'd0, e.eout});
            check("mantissa_out", {9'd0, bus.mantissa_out}, {9'd0, e.mout});
            check("zero", {31'd0, bus.zero}, {31'd0, e.z});
            check("overflow", {31'd0, bus.overflow}, {31'd0, e.o});
            check("underflow", {31'd0, bus.underflow}, {31'd0, e.u});
            @(posedge clk);
            #1;
            check("done_one_cycle", {31'd0, bus.done}, 32'd0);
            check("busy_after_done", {31'd0, bus.busy}, 32'd0);
            check("mantissa_held", {9'd0, bus.mantissa_out}, {9'd0, e.mout});
         end
      end
   endtask

   task automatic checkAllZero(input string tag);
      check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
      check({tag, "_done"}, {31'd0, bus.done}, 32'd0);
      check({tag, "_outs"}, {bus.sign_out, bus.exponent_out, bus.mantissa_out}, 32'd0);
      check({tag, "_flags"}, {29'd0, bus.zero, bus.overflow, bus.underflow}, 32'd0);
   endtask

   initial begin
      int doneCount;
      nChecks = 0;
      nFails  = 0;
      bus.start          = 1'b0;
      bus.sign_in        = 1'b0;
      bus.exponent_in    = 8'd0;
      bus.significand_in = 25'd0;

      //            sgn   ein      sin           eout     mout          z     o     u    lat
      vecs[0]  = '{1'b0, 8'd127, 25'h0C00001, 8'd127, 23'h400001, 1'b0, 1'b0, 1'b0, 1};
      vecs[1]  = '{1'b1, 8'd130, 25'h1800003, 8'd131, 23'h400001, 1'b0, 1'b0, 1'b0, 2};
      vecs[2]  = '{1'b0, 8'd100, 25'h0000010, 8'd81,  23'h000000, 1'b0, 1'b0, 1'b0, 20};
      vecs[3]  = '{1'b1, 8'd127, 25'h0000001, 8'd104, 23'h000000, 1'b0, 1'b0, 1'b0, 24};
      vecs[4]  = '{1'b0, 8'd254, 25'h1000000, 8'd255, 23'h000000, 1'b0, 1'b1, 1'b0, 2};
      vecs[5]  = '{1'b0, 8'd3,   25'h0000100, 8'd0,   23'h000400, 1'b0, 1'b0, 1'b1, 3};
      vecs[6]  = '{1'b1, 8'd77,  25'h0000000, 8'd0,   23'h000000, 1'b1, 1'b0, 1'b0, 1};
      vecs[7]  = '{1'b0, 8'd1,   25'h0400000, 8'd0,   23'h400000, 1'b0, 1'b0, 1'b1, 1};
      vecs[8]  = '{1'b1, 8'd253, 25'h1FFFFFF, 8'd254, 23'h7FFFFF, 1'b0, 1'b0, 1'b0, 2};
      vecs[9]  = '{1'b0, 8'd10,  25'h0400000, 8'd9,   23'h000000, 1'b0, 1'b0, 1'b0, 2};
      vecs[10] = '{1'b0, 8'd0,   25'h1000001, 8'd1,   23'h000001, 1'b0, 1'b0, 1'b0, 2};
      vecs[11] = '{1'b1, 8'd2,   25'h0400000, 8'd1,   23'h000000, 1'b0, 1'b0, 1'b0, 2};

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkAllZero("reset");
      reset = 1'b0;

      for (int i = 0; i < 12; i++) begin
         driveStart(vecs[i], 1'b1);
         check("busy_after_start", {31'd0, bus.busy}, 32'd1);
         waitDone(0);
      end

      // start while busy is ignored and the previous result stays visible
      driveStart(vecs[2], 1'b1);
      repeat (3) @(posedge clk);
      #1;
      bus.start          = 1'b1;
      bus.exponent_in    = 8'd5;
      bus.significand_in = 25'h0C00001;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("held_while_busy", {24'd0, bus.exponent_out}, {24'd0, vecs[11].eout});
      waitDone(4);
      doneCount = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) doneCount++;
      end
      check("ignored_start_no_done", doneCount, 0);

      // start coinciding with done is only accepted one cycle later
      driveStart(vecs[0], 1'b1);
      waitDone(0);
      driveStart(vecs[6], 1'b1);
      for (int i = 0; i < 4 && bus.done !== 1'b1; i++) begin
         @(posedge clk);
         #1;
      end
      check("done_before_overlap", {31'd0, bus.done}, 32'd1);
      void'(sbQ.pop_front());
      bus.start          = 1'b1;
      bus.sign_in        = vecs[9].sgn;
      bus.exponent_in    = vecs[9].ein;
      bus.significand_in = vecs[9].sin;
      sbQ.push_back(vecs[9]);
      @(posedge clk);
      #1;
      check("start_in_done_ignored", {31'd0, bus.busy}, 32'd0);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("start_after_done_accepted", {31'd0, bus.busy}, 32'd1);
      waitDone(0);

      // reset at cycle N+5 of a 20-shift operation aborts it without done
      tmpV = '{1'b1, 8'd100, 25'h0000008, 8'd80, 23'h000000, 1'b0, 1'b0, 1'b0, 21};
      driveStart(tmpV, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkAllZero("mid_reset");
      reset = 1'b0;
      doneCount = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) doneCount++;
      end
      check("aborted_no_done", doneCount, 0);
      driveStart(vecs[1], 1'b1);
      waitDone(0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/fp_normalizer.md
FP_NORMALIZER -- requirements
Module: fp_normalizer

Interface
REQ-001 The block SHALL have these ports, one clock domain, and registered outputs only:
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 start  input  1  one-cycle request; sampled only in IDLE.
REQ-005 sign_in  input  1  sign of the unnormalized result.
REQ-006 exponent_in  input  8  biased exponent of the unnormalized result.
REQ-007 significand_in  input  25  bit 24 = carry, bit 23 = hidden-bit position, bits 22:0 = fraction.
REQ-008 busy  output  1  high in every state other than IDLE.
REQ-009 done  output  1  one-cycle pulse when the outputs are valid.
REQ-010 sign_out  output  1  latched sign_in.
REQ-011 exponent_out  output  8  normalized biased exponent.
REQ-012 mantissa_out  output  23  normalized fraction, hidden bit removed; feeds the rounder directly.
REQ-013 zero  output  1  the significand was zero.
REQ-014 overflow  output  1  the exponent saturated to 255.
REQ-015 underflow  output  1  the result is denormal and exponent_out = 0.

Function
REQ-016 The FSM SHALL have states IDLE, CHECK, SHIFT_RIGHT, SHIFT_LEFT and DONE, with internal registers sig[24:0], exp[8:0] and sgn.
REQ-017 IDLE: when start = 1, the block SHALL latch sig, exp and sgn from the inputs, clear zero, overflow and underflow, and go to CHECK; start in any other state SHALL be ignored.
REQ-018 CHECK:
- sig = 0 -> zero = 1, exp = 0, go to DONE.
- else sig[24] = 1 -> go to SHIFT_RIGHT.
- else sig[23] = 1 -> go to DONE.
- else exp <= 1 -> underflow = 1, exp = 0, go to DONE.
- else -> go to SHIFT_LEFT.
REQ-019 SHIFT_RIGHT (exactly one cycle):
- sig = {1'b0, sig[24:1]}, with the bit shifted out ORed into the new sig[0] (sticky).
- exp = exp + 1.
- If the new exp >= 255: exp = 255, sig[22:0] = 0, overflow = 1.
- Go to DONE.
REQ-020 SHIFT_LEFT, one bit per cycle:
- sig = sig << 1, exp = exp - 1.
- If the new sig[23] = 1, go to DONE.
- Else if the new exp = 1, set underflow = 1 and exp = 0, and go to DONE with sig unshifted further.
- Else stay in SHIFT_LEFT.
REQ-021 DONE: done = 1 for exactly this cycle, then go to IDLE.
REQ-022 In DONE, mantissa_out = sig[22:0], exponent_out = exp[7:0] and sign_out = sgn; these SHALL be held unchanged until the next accepted start.
REQ-023 Latency, with start sampled at edge N:
- Already normalized, zero or underflow-in-CHECK: done is high in cycle N+2.
- Carry: done is high in cycle N+3.
- Left shift by k: done is high in cycle N+2+k (max k = 23 -> N+25).
REQ-024 The sign SHALL pass through unmodified, including for zero results.
REQ-025 Exponent arithmetic SHALL use 9 bits internally so that no wrap-around is possible; exponent_out SHALL never wrap.
REQ-026 done and start in the same cycle: DONE returns to IDLE first, so start SHALL only be accepted in the following cycle.

Reset
REQ-027 reset = 1 at a clock edge SHALL force IDLE and set all outputs to 0.
REQ-028 reset SHALL take priority over start and over any in-progress shift.
REQ-029 A reset mid-operation SHALL abort the operation with no done pulse; the next start after reset SHALL behave as from power-up.

Verification
REQ-030 Already normalized: sig = 0x0C00001, exp = 127, start -> done at N+2, exponent_out = 127, mantissa_out = 0x400001, all flags 0.
REQ-031 Carry: sig = 0x1800003, exp = 130 -> done at N+3, exponent_out = 131, mantissa_out = 0x400001 (sticky retained), overflow = 0.
REQ-032 Left shift: sig = 0x0000010, exp = 100 -> done at N+21, exponent_out = 81, mantissa_out = 0; also sig = 0x0000001, exp = 127 -> done at N+25, exponent_out = 104.
REQ-033 Boundaries:
- sig = 0x1000000, exp = 254 -> overflow = 1, exponent_out = 255, mantissa_out = 0.
- sig = 0x0000100, exp = 3 -> underflow = 1, exponent_out = 0, mantissa_out = 0x000400.
- sig = 0 -> zero = 1, exponent_out = 0.
REQ-034 Control: start pulsed while busy is ignored with results unchanged; reset asserted in cycle N+5 of a 20-shift operation -> no done pulse, outputs 0, busy = 0 next cycle; a new start then completes normally.
